// File: rtl/memwb_pipe_stage.sv
// MEM/WB elastic stage register: head + skid entries, valid/ready handshake, flush, OR-merged error.
// Optional MEMWB_STICKY_ERR_EN adds err_sticky, set when an erroneous entry is consumed.
module memwb_pipe_stage #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned REG_ADDR_W = 3,
  parameter int unsigned CTRL_W     = 3,
  parameter int unsigned ERR_SRCS   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     mem_data_in,
  input  logic [DATA_W-1:0]     alu_res_in,
  input  logic [REG_ADDR_W-1:0] write_reg_in,
  input  logic [CTRL_W-1:0]     ctrl_in,
  input  logic                  write_reg_valid_in,
  input  logic [ERR_SRCS-1:0]   err_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     mem_data_out,
  output logic [DATA_W-1:0]     alu_res_out,
  output logic [REG_ADDR_W-1:0] write_reg_out,
  output logic [CTRL_W-1:0]     ctrl_out,
  output logic                  write_reg_valid_out,
  output logic                  err_out
`ifdef MEMWB_STICKY_ERR_EN
  ,
  output logic                  err_sticky
`endif
);

  typedef struct packed {
    logic [DATA_W-1:0]     mem_data;
    logic [DATA_W-1:0]     alu_res;
    logic [REG_ADDR_W-1:0] write_reg;
    logic [CTRL_W-1:0]     ctrl;
    logic                  write_reg_valid;
    logic                  err;
  } payload_t;

  payload_t head;
  payload_t skid;
  payload_t in_pl;
  logic     head_valid;
  logic     skid_valid;
  logic     accept;
  logic     consume;

  always_comb begin
    in_pl.mem_data        = mem_data_in;
    in_pl.alu_res         = alu_res_in;
    in_pl.write_reg       = write_reg_in;
    in_pl.ctrl            = ctrl_in;
    in_pl.write_reg_valid = write_reg_valid_in;
    in_pl.err             = |err_in;
  end

  // in_ready depends only on stored state, never on out_ready
  assign in_ready = ~skid_valid;
  assign accept   = in_valid & in_ready & ~flush;
  assign consume  = head_valid & out_ready;

  // Head/skid update; skid only ever drains into head so ordering is preserved
  always_ff @(posedge clk) begin
    if (rst) begin
      head_valid <= 1'b0;
      skid_valid <= 1'b0;
      head       <= '0;
      skid       <= '0;
    end else if (flush) begin
      head_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (skid_valid) begin
      if (consume) begin
        head       <= skid;
        skid_valid <= 1'b0;
      end
    end else if (head_valid) begin
      if (consume) begin
        head_valid <= accept;
        if (accept) head <= in_pl;
      end else if (accept) begin
        skid       <= in_pl;
        skid_valid <= 1'b1;
      end
    end else if (accept) begin
      head       <= in_pl;
      head_valid <= 1'b1;
    end
  end

  // Bubbles must never write the register file, so control-like fields are gated
  assign out_valid           = head_valid;
  assign mem_data_out        = head.mem_data;
  assign alu_res_out         = head.alu_res;
  assign write_reg_out       = head.write_reg;
  assign ctrl_out            = head.ctrl & {CTRL_W{head_valid}};
  assign write_reg_valid_out = head.write_reg_valid & head_valid;
  assign err_out             = head.err & head_valid;

`ifdef MEMWB_STICKY_ERR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err_sticky <= 1'b0;
    end else if (consume & err_out) begin
      err_sticky <= 1'b1;
    end
  end
`endif

endmodule
